// File: rtl/climate_regulator.sv
// climate_regulator
//   Accepts range-checked temperature/humidity samples, keeps a 4-sample
//   moving average per channel and drives fan/heater from a hysteresis FSM
//   (IDLE, COOLING, HEATING, FAULT). FAULT is forced by three consecutive
//   rejected samples or by a sample watchdog timeout. In FAULT the fan stays
//   on and the alarm is raised.
// Ports
//   clock, reset        : system clock, asynchronous active-high reset
//   sample_valid        : one-cycle strobe qualifying temp_data / hum_data
//   temp_data, hum_data : 16-bit unsigned degC / %RH samples
//   temp_setpoint       : 8-bit target temperature
//   hum_limit           : 8-bit maximum humidity
//   temp_avg, hum_avg   : registered 4-sample averages
//   avg_valid           : window holds 4 accepted samples
//   fan_on, heater_on   : registered actuator commands (never both high)
//   alarm               : sensor fault indication
//   debug_state         : FSM encoding IDLE=0 COOLING=1 HEATING=2 FAULT=3
module climate_regulator #(
  parameter int unsigned HYST      = 2,
  parameter logic [31:0] MIN_DWELL = 32'd5_000_000,
  parameter logic [31:0] TIMEOUT   = 32'd50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] temp_data,
  input  logic [15:0] hum_data,
  input  logic [7:0]  temp_setpoint,
  input  logic [7:0]  hum_limit,
  output logic [15:0] temp_avg,
  output logic [15:0] hum_avg,
  output logic        avg_valid,
  output logic        fan_on,
  output logic        heater_on,
  output logic        alarm,
  output logic [1:0]  debug_state
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SUM_W  = DATA_W + 2;
  localparam logic [8:0]  HYST9  = 9'(HYST);
  localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(100);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOLING = 2'd1,
    HEATING = 2'd2,
    FAULT   = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [8:0] sat_sub9(input logic [8:0] a, input logic [8:0] b);
    return (a > b) ? a - b : 9'd0;
  endfunction

  // Average is a plain truncating divide by four.
  function automatic logic [DATA_W-1:0] avg4(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:2];
  endfunction

  logic [DATA_W-1:0] temp_win_p0 [4];
  logic [DATA_W-1:0] hum_win_p0  [4];
  logic [SUM_W-1:0]  temp_sum_p0, hum_sum_p0;
  logic [SUM_W-1:0]  temp_sum_nxt, hum_sum_nxt;
  logic              vld_p1;
  logic [2:0]        fill_cnt;
  logic [1:0]        rej_cnt;
  logic [31:0]       watchdog, dwell;
  state_t            state, state_nxt;

  logic accept, reject, fault_cond, fault_entry, eval_p1;
  logic [8:0] t9, h9, sp9, lim9, sp_hi, lim_lo, t_plus;

  // Stage p0: range check and window/sum update on the accepting edge.
  // The running sum drops the oldest entry and adds the new one, so the
  // sum always covers the four window slots including the new sample.
  assign accept = sample_valid && (temp_data <= MAX_VAL) && (hum_data <= MAX_VAL);
  assign reject = sample_valid && !accept;

  assign temp_sum_nxt = temp_sum_p0 + SUM_W'(temp_data) - SUM_W'(temp_win_p0[3]);
  assign hum_sum_nxt  = hum_sum_p0  + SUM_W'(hum_data)  - SUM_W'(hum_win_p0[3]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        temp_win_p0[i] <= '0;
        hum_win_p0[i]  <= '0;
      end
      temp_sum_p0 <= '0;
      hum_sum_p0  <= '0;
      temp_avg    <= '0;
      hum_avg     <= '0;
    end else if (accept) begin
      temp_win_p0[0] <= temp_data;
      hum_win_p0[0]  <= hum_data;
      for (int i = 1; i < 4; i++) begin
        temp_win_p0[i] <= temp_win_p0[i-1];
        hum_win_p0[i]  <= hum_win_p0[i-1];
      end
      temp_sum_p0 <= temp_sum_nxt;
      hum_sum_p0  <= hum_sum_nxt;
      temp_avg    <= avg4(temp_sum_nxt);
      hum_avg     <= avg4(hum_sum_nxt);
    end
  end

  // Stage p1: averages visible; FSM evaluates here, state lands one edge later.
  // Compares are 9 bits wide so setpoint+HYST cannot wrap; accepted data
  // never exceeds 100, so the low 9 bits of the averages are exact.
  assign avg_valid   = (fill_cnt == 3'd4);
  assign eval_p1     = vld_p1 && avg_valid;
  assign fault_cond  = (rej_cnt == 2'd3) || (watchdog >= TIMEOUT);
  assign fault_entry = fault_cond && (state != FAULT);

  assign t9     = temp_avg[8:0];
  assign h9     = hum_avg[8:0];
  assign sp9    = {1'b0, temp_setpoint};
  assign lim9   = {1'b0, hum_limit};
  assign sp_hi  = sp9 + HYST9;
  assign t_plus = t9 + HYST9;
  assign lim_lo = sat_sub9(lim9, HYST9);

  always_comb begin
    state_nxt = state;
    if (fault_cond) begin
      state_nxt = FAULT;
    end else if (eval_p1) begin
      case (state)
        IDLE: begin
          if (t9 >= sp_hi || h9 > lim9)  state_nxt = COOLING;
          else if (t_plus <= sp9)        state_nxt = HEATING;
        end
        COOLING: begin
          if (dwell >= MIN_DWELL && t9 <= sp9 && h9 <= lim_lo) state_nxt = IDLE;
        end
        HEATING: begin
          if (h9 > lim9)                                 state_nxt = COOLING;
          else if (dwell >= MIN_DWELL && t9 >= sp9)      state_nxt = IDLE;
        end
        FAULT:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p2: state, counters and Moore outputs registered together.
  // A FAULT entry clears the fill count even if a sample is accepted on the
  // same edge, so the window must refill with four fresh samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vld_p1    <= 1'b0;
      fill_cnt  <= '0;
      rej_cnt   <= '0;
      watchdog  <= '0;
      dwell     <= '0;
      fan_on    <= 1'b0;
      heater_on <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= accept;

      if (fault_entry)                    fill_cnt <= '0;
      else if (accept && fill_cnt != 3'd4) fill_cnt <= fill_cnt + 3'd1;

      if (accept)                          rej_cnt <= '0;
      else if (reject && rej_cnt != 2'd3)  rej_cnt <= rej_cnt + 2'd1;

      watchdog <= sample_valid ? 32'd0 : sat_inc32(watchdog);

      if (state_nxt != state)                        dwell <= '0;
      else if (state == COOLING || state == HEATING) dwell <= sat_inc32(dwell);

      fan_on    <= (state_nxt == COOLING) || (state_nxt == FAULT);
      heater_on <= (state_nxt == HEATING);
      alarm     <= (state_nxt == FAULT);
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_climate_regulator.sv
module tb_climate_regulator;

  localparam int unsigned HYST      = 2;
  localparam logic [31:0] MIN_DWELL = 32'd40;
  localparam logic [31:0] TIMEOUT   = 32'd100;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] temp_data, hum_data;
  logic [7:0]  temp_setpoint, hum_limit;
  logic [15:0] temp_avg, hum_avg;
  logic        avg_valid, fan_on, heater_on, alarm;
  logic [1:0]  debug_state;

  climate_regulator #(
    .HYST      (HYST),
    .MIN_DWELL (MIN_DWELL),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .temp_data     (temp_data),
    .hum_data      (hum_data),
    .temp_setpoint (temp_setpoint),
    .hum_limit     (hum_limit),
    .temp_avg      (temp_avg),
    .hum_avg       (hum_avg),
    .avg_valid     (avg_valid),
    .fan_on        (fan_on),
    .heater_on     (heater_on),
    .alarm         (alarm),
    .debug_state   (debug_state)
  );

  always #5 clock = ~clock;

  int    n_chk = 0;
  int    n_err = 0;
  string scen  = "init";

  typedef struct {
    logic [15:0] t;
    logic [15:0] h;
    logic        v;
  } exp_t;

  exp_t        sb_q[$];
  int          mt[4], mh[4];
  int          mfill;
  logic [15:0] last_t, last_h;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0d, expected %0d", scen, tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mt[i] = 0;
      mh[i] = 0;
    end
    mfill  = 0;
    last_t = '0;
    last_h = '0;
    sb_q.delete();
  endtask

  task automatic model_accept(input int t, input int h);
    exp_t e;
    for (int i = 3; i > 0; i--) begin
      mt[i] = mt[i-1];
      mh[i] = mh[i-1];
    end
    mt[0] = t;
    mh[0] = h;
    if (mfill < 4) mfill++;
    e.t = 16'((mt[0] + mt[1] + mt[2] + mt[3]) / 4);
    e.h = 16'((mh[0] + mh[1] + mh[2] + mh[3]) / 4);
    e.v = (mfill == 4);
    last_t = e.t;
    last_h = e.h;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One sample per call; checks the average in the cycle after acceptance.
  task automatic send(input int t, input int h);
    exp_t e;
    logic acc;
    acc = (t <= 100) && (h <= 100);
    sample_valid = 1'b1;
    temp_data    = 16'(t);
    hum_data     = 16'(h);
    if (acc) model_accept(t, h);
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    if (acc) begin
      e = sb_q.pop_front();
      check_eq("temp_avg", 32'(temp_avg), 32'(e.t));
      check_eq("hum_avg", 32'(hum_avg), 32'(e.h));
      check_eq("avg_valid", 32'(avg_valid), 32'(e.v));
    end else begin
      check_eq("temp_hold", 32'(temp_avg), 32'(last_t));
      check_eq("hum_hold", 32'(hum_avg), 32'(last_h));
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_outs(input logic [1:0] st, input logic fan, input logic heat, input logic alm);
    check_eq("state", 32'(debug_state), 32'(st));
    check_eq("fan_on", 32'(fan_on), 32'(fan));
    check_eq("heater_on", 32'(heater_on), 32'(heat));
    check_eq("alarm", 32'(alarm), 32'(alm));
  endtask

  always @(negedge clock) begin
    check_eq("fan_heater_excl", 32'(fan_on & heater_on), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    reset         = 1'b1;
    sample_valid  = 1'b0;
    temp_data     = '0;
    hum_data      = '0;
    temp_setpoint = 8'd25;
    hum_limit     = 8'd70;
    model_reset();

    scen = "reset";
    tick(2);
    check_outs(2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("avg_valid", 32'(avg_valid), 32'd0);
    check_eq("temp_avg", 32'(temp_avg), 32'd0);
    check_eq("hum_avg", 32'(hum_avg), 32'd0);
    reset = 1'b0;

    scen = "heat";
    repeat (4) send(20, 50);
    check_eq("state_c1", 32'(debug_state), 32'd0);
    tick(1);
    check_outs(2'd2, 1'b0, 1'b1, 1'b0);

    scen = "cool_dwell";
    do_reset();
    repeat (4) send(28, 50);
    check_eq("state_c1", 32'(debug_state), 32'd0);
    tick(1);
    check_outs(2'd1, 1'b1, 1'b0, 1'b0);
    repeat (4) send(25, 50);
    tick(1);
    check_outs(2'd1, 1'b1, 1'b0, 1'b0);
    tick(45);
    check_outs(2'd1, 1'b1, 1'b0, 1'b0);
    send(25, 50);
    tick(1);
    check_outs(2'd0, 1'b0, 1'b0, 1'b0);

    scen = "fault_rej";
    do_reset();
    repeat (4) send(20, 50);
    tick(1);
    check_eq("state_heat", 32'(debug_state), 32'd2);
    repeat (3) send(150, 50);
    check_eq("state_pre", 32'(debug_state), 32'd2);
    tick(1);
    check_outs(2'd3, 1'b1, 1'b0, 1'b1);
    check_eq("avg_valid", 32'(avg_valid), 32'd0);
    mfill = 0;
    repeat (4) send(25, 50);
    check_eq("state_c1", 32'(debug_state), 32'd3);
    tick(1);
    check_outs(2'd0, 1'b0, 1'b0, 1'b0);

    scen = "timeout";
    do_reset();
    tick(100);
    check_outs(2'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_outs(2'd3, 1'b1, 1'b0, 1'b1);

    scen = "heat_to_cool";
    do_reset();
    repeat (4) send(20, 50);
    tick(1);
    check_eq("state_heat", 32'(debug_state), 32'd2);
    send(20, 80);
    send(20, 80);
    check_eq("state_h57", 32'(debug_state), 32'd2);
    send(20, 80);
    check_eq("state_h65", 32'(debug_state), 32'd2);
    tick(1);
    check_outs(2'd1, 1'b1, 1'b0, 1'b0);

    scen = "rst_in_cool";
    do_reset();
    repeat (4) send(28, 50);
    tick(1);
    check_eq("state_cool", 32'(debug_state), 32'd1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_outs(2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("avg_valid", 32'(avg_valid), 32'd0);
    check_eq("temp_avg", 32'(temp_avg), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    send(20, 50);

    scen = "range_edge";
    do_reset();
    send(100, 100);
    send(101, 0);
    send(0, 101);
    send(10, 10);
    send(101, 0);
    send(101, 0);
    tick(2);
    check_eq("state_two_rej", 32'(debug_state), 32'd0);
    send(150, 0);
    tick(1);
    check_eq("state_three_rej", 32'(debug_state), 32'd3);

    scen = "temp_hyst";
    do_reset();
    repeat (4) send(26, 50);
    tick(1);
    check_eq("state_26", 32'(debug_state), 32'd0);
    send(23, 50);
    send(23, 50);
    check_eq("state_25", 32'(debug_state), 32'd0);
    send(23, 50);
    check_eq("state_24", 32'(debug_state), 32'd0);
    send(23, 50);
    check_eq("state_23", 32'(debug_state), 32'd2);
    tick(1);
    check_outs(2'd2, 1'b0, 1'b1, 1'b0);

    scen = "hum_edge";
    do_reset();
    repeat (4) send(25, 70);
    tick(1);
    check_eq("state_h70", 32'(debug_state), 32'd0);
    repeat (4) send(25, 71);
    check_eq("state_c1", 32'(debug_state), 32'd0);
    tick(1);
    check_outs(2'd1, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
